// File: rtl/stick_sync_pkg.sv
// rtl/stick_sync_pkg.sv - shared constants and state encoding for the master-sync generator
package stick_sync_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_INT   = 2'd1;
  localparam logic [1:0] MODE_EXT   = 2'd2;
  localparam logic [1:0] MODE_WHEEL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } pulse_state_t;

  localparam int DEF_MIN_LOW  = 8;
  localparam int DEF_MIN_HIGH = 8;

endpackage

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - input synchronisers, x4 quadrature decode, wheel position and error flag
module quad_decoder
  import stick_sync_pkg::*;
#(
  parameter int QUAD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sync,
  input  logic              i_adp,
  input  logic              i_bdp,
  input  logic              i_clr_err,
  output logic              o_sync_rise,
  output logic              o_step,
  output logic              o_fwd,
  output logic [QUAD_W-1:0] o_pos,
  output logic              o_err
);

  logic [SYNC_STAGES-1:0] r_sync_sh;
  logic [SYNC_STAGES-1:0] r_a_sh;
  logic [SYNC_STAGES-1:0] r_b_sh;
  logic                   r_sync_prev;
  logic                   r_a_prev;
  logic                   r_b_prev;
  logic [QUAD_W-1:0]      r_pos;
  logic                   r_err;

  logic w_sync;
  logic w_a;
  logic w_b;
  logic w_a_chg;
  logic w_b_chg;
  logic w_bad;
  logic w_step;
  logic w_fwd;

  assign w_sync  = r_sync_sh[SYNC_STAGES-1];
  assign w_a     = r_a_sh[SYNC_STAGES-1];
  assign w_b     = r_b_sh[SYNC_STAGES-1];
  assign w_a_chg = w_a ^ r_a_prev;
  assign w_b_chg = w_b ^ r_b_prev;
  assign w_bad   = w_a_chg & w_b_chg;
  assign w_step  = w_a_chg ^ w_b_chg;
  // A leading B (00->10->11->01) always has old A equal to new B
  assign w_fwd   = ~(r_a_prev ^ w_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_sh   <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sync_prev <= 1'b0;
      r_a_prev    <= 1'b0;
      r_b_prev    <= 1'b0;
      r_pos       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_sync_sh   <= {r_sync_sh[SYNC_STAGES-2:0], i_sync};
      r_a_sh      <= {r_a_sh[SYNC_STAGES-2:0], i_adp};
      r_b_sh      <= {r_b_sh[SYNC_STAGES-2:0], i_bdp};
      r_sync_prev <= w_sync;
      r_a_prev    <= w_a;
      r_b_prev    <= w_b;
      if (w_step) begin
        r_pos <= w_fwd ? r_pos + QUAD_W'(1) : r_pos - QUAD_W'(1);
      end
      if (i_clr_err) begin
        r_err <= 1'b0;
      end else if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_sync_rise = w_sync & ~r_sync_prev;
  assign o_step      = w_step;
  assign o_fwd       = w_fwd;
  assign o_pos       = r_pos;
  assign o_err       = r_err;

endmodule

// File: rtl/msync_gen.sv
// rtl/msync_gen.sv - master-sync pulse generator with internal, external and wheel trigger sources
module msync_gen
  import stick_sync_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int PW_W        = 8,
  parameter int QUAD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = DEF_MIN_LOW,
  parameter int MIN_HIGH    = DEF_MIN_HIGH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_load,
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [PW_W-1:0]   i_pulse_w,
  input  logic [QUAD_W-1:0] i_wheel_step,
  input  logic              i_sync,
  input  logic              i_adp,
  input  logic              i_bdp,
  output logic              o_msync_n,
  output logic              o_busy,
  output logic [31:0]       o_sync_cnt,
  output logic [QUAD_W-1:0] o_wheel_pos,
  output logic              o_overrun,
  output logic              o_quad_err
);

  localparam logic [PW_W-1:0] MIN_LOW_W  = PW_W'(MIN_LOW);
  localparam logic [PW_W-1:0] HOLD_LAST  = PW_W'(MIN_HIGH - 1);

  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_period;
  logic [PW_W-1:0]   r_pulse_w;
  logic [QUAD_W-1:0] r_wheel_step;
  logic [CNT_W-1:0]  r_cnt;
  logic [QUAD_W-1:0] r_acc;
  logic              r_trig;
  pulse_state_t      r_state;
  logic [PW_W-1:0]   r_tcnt;
  logic              r_msync_n;
  logic              r_busy;
  logic [31:0]       r_sync_cnt;
  logic              r_overrun;

  pulse_state_t      w_state_nx;
  logic [PW_W-1:0]   w_tcnt_nx;
  logic [PW_W-1:0]   w_width;
  logic              w_start;
  logic              w_drop;
  logic              w_trig;
  logic              w_wheel_hit;
  logic [QUAD_W-1:0] w_acc_inc;
  logic [QUAD_W-1:0] w_acc_nx;
  logic              w_sync_rise;
  logic              w_step;
  logic              w_fwd;

  quad_decoder #(
    .QUAD_W      (QUAD_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_quad (
    .clk         (clk),
    .rst         (rst),
    .i_sync      (i_sync),
    .i_adp       (i_adp),
    .i_bdp       (i_bdp),
    .i_clr_err   (i_cfg_load),
    .o_sync_rise (w_sync_rise),
    .o_step      (w_step),
    .o_fwd       (w_fwd),
    .o_pos       (o_wheel_pos),
    .o_err       (o_quad_err)
  );

  // Reverse steps only unwind progress towards the next trigger, never below zero
  always_comb begin
    w_acc_inc   = r_acc + QUAD_W'(1);
    w_acc_nx    = r_acc;
    w_wheel_hit = 1'b0;
    if (r_mode == MODE_WHEEL && w_step) begin
      if (w_fwd) begin
        if (r_wheel_step != '0 && w_acc_inc == r_wheel_step) begin
          w_wheel_hit = 1'b1;
          w_acc_nx    = '0;
        end else begin
          w_acc_nx = w_acc_inc;
        end
      end else if (r_acc != '0) begin
        w_acc_nx = r_acc - QUAD_W'(1);
      end
    end
  end

  always_comb begin
    w_trig = 1'b0;
    case (r_mode)
      MODE_INT:   w_trig = (r_period != '0) && (r_cnt == '0);
      MODE_EXT:   w_trig = w_sync_rise;
      MODE_WHEEL: w_trig = w_wheel_hit;
      default:    w_trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_OFF;
      r_period     <= '0;
      r_pulse_w    <= '0;
      r_wheel_step <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_trig       <= 1'b0;
    end else begin
      r_trig <= w_trig;
      if (i_cfg_load) begin
        r_mode       <= i_mode;
        r_period     <= i_period;
        r_pulse_w    <= i_pulse_w;
        r_wheel_step <= i_wheel_step;
        r_cnt        <= '0;
        r_acc        <= '0;
      end else begin
        r_acc <= w_acc_nx;
        if (r_mode == MODE_INT && r_period != '0) begin
          r_cnt <= (r_cnt >= r_period - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign w_width = (r_pulse_w < MIN_LOW_W) ? MIN_LOW_W : r_pulse_w;

  always_comb begin
    w_state_nx = r_state;
    w_tcnt_nx  = r_tcnt;
    w_start    = 1'b0;
    w_drop     = r_trig && (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (r_trig) begin
          w_state_nx = ST_PULSE;
          w_tcnt_nx  = w_width - PW_W'(1);
          w_start    = 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_tcnt == '0) begin
          w_state_nx = ST_HOLDOFF;
          w_tcnt_nx  = HOLD_LAST;
        end else begin
          w_tcnt_nx = r_tcnt - PW_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (r_tcnt == '0) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_tcnt_nx = r_tcnt - PW_W'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_tcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
    end
  end

  // Outputs registered from the next state so msync_n is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msync_n  <= 1'b1;
      r_busy     <= 1'b0;
      r_sync_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_msync_n <= (w_state_nx != ST_PULSE);
      r_busy    <= (w_state_nx != ST_IDLE);
      if (w_start) begin
        r_sync_cnt <= r_sync_cnt + 32'd1;
      end
      if (i_cfg_load) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_msync_n  = r_msync_n;
  assign o_busy     = r_busy;
  assign o_sync_cnt = r_sync_cnt;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_msync_gen.sv
// tb/tb_msync_gen.sv - randomized self-checking bench for msync_gen against an event-level model
module tb_msync_gen;

  localparam int CNT_W    = 24;
  localparam int PW_W     = 8;
  localparam int QUAD_W   = 16;
  localparam int SS       = 2;
  localparam int MIN_LOW  = 8;
  localparam int MIN_HIGH = 8;
  localparam int MAXE     = 16384;

  logic              clk;
  logic              rst;
  logic              cfg_load;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  period;
  logic [PW_W-1:0]   pulse_w;
  logic [QUAD_W-1:0] wheel_step;
  logic              sync;
  logic              adp;
  logic              bdp;
  logic              msync_n;
  logic              busy;
  logic [31:0]       sync_cnt;
  logic [QUAD_W-1:0] wheel_pos;
  logic              overrun;
  logic              quad_err;

  msync_gen #(
    .CNT_W       (CNT_W),
    .PW_W        (PW_W),
    .QUAD_W      (QUAD_W),
    .SYNC_STAGES (SS),
    .MIN_LOW     (MIN_LOW),
    .MIN_HIGH    (MIN_HIGH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_load   (cfg_load),
    .i_mode       (mode),
    .i_period     (period),
    .i_pulse_w    (pulse_w),
    .i_wheel_step (wheel_step),
    .i_sync       (sync),
    .i_adp        (adp),
    .i_bdp        (bdp),
    .o_msync_n    (msync_n),
    .o_busy       (busy),
    .o_sync_cnt   (sync_cnt),
    .o_wheel_pos  (wheel_pos),
    .o_overrun    (overrun),
    .o_quad_err   (quad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int e;
  int m_base;
  bit hs [MAXE];
  bit ha [MAXE];
  bit hb [MAXE];

  // Model: shadow config, pulse window [m_ps, m_pe), idle again from edge m_idle_from
  int                m_mode, m_per, m_pw, m_step;
  bit                m_trig;
  int                m_ps, m_pe, m_idle_from, m_int_next, m_acc;
  logic [31:0]       m_cnt;
  logic [QUAD_W-1:0] m_pos;
  bit                m_ovr, m_qerr;
  logic [31:0]       cnt0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic bit hval(input int which, input int i);
    if (i <= m_base || i >= MAXE) return 1'b0;
    case (which)
      0:       return hs[i];
      1:       return ha[i];
      default: return hb[i];
    endcase
  endfunction

  function automatic int gidx(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_per = 0; m_pw = 0; m_step = 0;
    m_trig = 1'b0; m_ps = 0; m_pe = 0; m_idle_from = 0; m_int_next = 0; m_acc = 0;
    m_cnt = '0; m_pos = '0; m_ovr = 1'b0; m_qerr = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    int d;
    bit nt, cs, ps, ca, cb, pa, pb;
    w = (m_pw < MIN_LOW) ? MIN_LOW : m_pw;
    if (m_trig) begin
      if (e - 1 >= m_idle_from) begin
        m_ps = e;
        m_pe = e + w;
        m_idle_from = e + w + MIN_HIGH;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    nt = 1'b0;
    cs = hval(0, e - SS); ps = hval(0, e - SS - 1);
    ca = hval(1, e - SS); pa = hval(1, e - SS - 1);
    cb = hval(2, e - SS); pb = hval(2, e - SS - 1);
    if (m_mode == 1 && m_per != 0 && e == m_int_next) begin
      nt = 1'b1;
      m_int_next = e + m_per;
    end
    if (m_mode == 2 && cs && !ps) nt = 1'b1;
    if (ca != pa && cb != pb) begin
      m_qerr = 1'b1;
    end else if (ca != pa || cb != pb) begin
      d = (gidx(ca, cb) - gidx(pa, pb) + 4) % 4;
      if (d == 1) begin
        m_pos = m_pos + 1'b1;
        if (m_mode == 3) begin
          m_acc++;
          if (m_step != 0 && m_acc == m_step) begin
            nt = 1'b1;
            m_acc = 0;
          end
        end
      end else begin
        m_pos = m_pos - 1'b1;
        if (m_mode == 3 && m_acc > 0) m_acc--;
      end
    end
    m_trig = nt;
    if (cfg_load) begin
      m_mode = int'(mode); m_per = int'(period); m_pw = int'(pulse_w); m_step = int'(wheel_step);
      m_int_next = e + 1; m_acc = 0; m_ovr = 1'b0; m_qerr = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("msync_n", {31'b0, msync_n}, (e >= m_ps && e < m_pe) ? 32'd0 : 32'd1);
    check_eq("busy", {31'b0, busy}, (e < m_idle_from) ? 32'd1 : 32'd0);
    check_eq("sync_cnt", sync_cnt, m_cnt);
    check_eq("wheel_pos", {16'b0, wheel_pos}, {16'b0, m_pos});
    check_eq("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    check_eq("quad_err", {31'b0, quad_err}, {31'b0, m_qerr});
  endtask

  task automatic do_tick();
    @(posedge clk);
    e++;
    if (e < MAXE) begin
      hs[e] = sync; ha[e] = adp; hb[e] = bdp;
    end
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic load_cfg(input int m, input int p, input int w, input int s);
    mode = 2'(m); period = CNT_W'(p); pulse_w = PW_W'(w); wheel_step = QUAD_W'(s);
    cfg_load = 1'b1;
    do_tick();
    cfg_load = 1'b0;
  endtask

  task automatic quiesce();
    load_cfg(0, 0, 0, 0);
    repeat (40) do_tick();
  endtask

  task automatic quad_step(input bit fwd, input int hold);
    if (fwd) begin
      if (adp == bdp) adp = ~adp; else bdp = ~bdp;
    end else begin
      if (adp == bdp) bdp = ~bdp; else adp = ~adp;
    end
    repeat (hold) do_tick();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_msync_n"}, {31'b0, msync_n}, 32'd1);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_sync_cnt"}, sync_cnt, 32'd0);
    check_eq({tag, "_wheel_pos"}, {16'b0, wheel_pos}, 32'd0);
    check_eq({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    check_eq({tag, "_quad_err"}, {31'b0, quad_err}, 32'd0);
  endtask

  initial begin
    int r;
    n_vec = 0; n_err = 0; e = 0; m_base = 0;
    rst = 1'b1; cfg_load = 1'b0; mode = '0; period = '0; pulse_w = '0; wheel_step = '0;
    sync = 1'b0; adp = 1'b0; bdp = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("in_reset");
    rst = 1'b0;
    #1;
    check_reset_state("after_reset");

    // Internal timer, period 100, width 10
    load_cfg(1, 100, 10, 0);
    repeat (500) do_tick();
    check_eq("int_cnt_5", sync_cnt, 32'd5);
    check_eq("int_no_overrun", {31'b0, overrun}, 32'd0);
    quiesce();

    // Width clamp and overrun at period 12
    cnt0 = m_cnt;
    load_cfg(1, 12, 2, 0);
    repeat (100) do_tick();
    check_eq("clamp_overrun", {31'b0, overrun}, 32'd1);
    check_eq("clamp_pulses", sync_cnt - cnt0, 32'd5);
    quiesce();

    // External sync latency and a dropped second edge
    cnt0 = m_cnt;
    load_cfg(2, 0, 10, 0);
    repeat (3) do_tick();
    sync = 1'b1;
    do_tick();
    do_tick();
    do_tick();
    check_eq("ext_not_yet", {31'b0, msync_n}, 32'd1);
    sync = 1'b0;
    do_tick();
    check_eq("ext_fall", {31'b0, msync_n}, 32'd0);
    do_tick();
    sync = 1'b1;
    repeat (26) do_tick();
    check_eq("ext_overrun", {31'b0, overrun}, 32'd1);
    check_eq("ext_pulses", sync_cnt - cnt0, 32'd1);
    sync = 1'b0;
    quiesce();

    // Wheel: step 4
    cnt0 = m_cnt;
    load_cfg(3, 0, 0, 4);
    repeat (8) quad_step(1'b1, 6);
    repeat (20) do_tick();
    check_eq("wheel_pos_8", {16'b0, wheel_pos}, 32'd8);
    check_eq("wheel_pulses_2", sync_cnt - cnt0, 32'd2);
    repeat (3) quad_step(1'b0, 6);
    repeat (7) quad_step(1'b1, 6);
    repeat (20) do_tick();
    check_eq("wheel_pos_12", {16'b0, wheel_pos}, 32'd12);
    check_eq("wheel_pulses_3", sync_cnt - cnt0, 32'd3);

    // Illegal double transition
    adp = ~adp; bdp = ~bdp;
    repeat (4) do_tick();
    check_eq("qerr_set", {31'b0, quad_err}, 32'd1);
    check_eq("qerr_pos_held", {16'b0, wheel_pos}, 32'd12);
    adp = ~adp; bdp = ~bdp;
    repeat (4) do_tick();
    load_cfg(3, 0, 0, 4);
    check_eq("qerr_cleared", {31'b0, quad_err}, 32'd0);
    quiesce();

    // Random phases
    for (int ph = 0; ph < 12; ph++) begin
      load_cfg(int'($urandom % 4), ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 40)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 5)));
      for (int i = 0; i < 150; i++) begin
        if ($urandom % 8 == 0) sync = ~sync;
        r = int'($urandom % 40);
        if (r < 6) quad_step(r < 4, 0);
        else if (r == 39) begin adp = ~adp; bdp = ~bdp; end
        cfg_load = ($urandom % 100 == 0);
        do_tick();
        cfg_load = 1'b0;
      end
    end

    // Asynchronous reset during a pulse
    sync = 1'b0; adp = 1'b0; bdp = 1'b0;
    load_cfg(1, 30, 20, 0);
    for (int i = 0; i < 100 && !(e >= m_ps && e < m_pe); i++) do_tick();
    check_eq("pre_rst_in_pulse", {31'b0, msync_n}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    @(posedge clk);
    model_reset();
    m_base = e;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) do_tick();
    check_eq("post_rst_no_pulses", sync_cnt, 32'd0);
    check_eq("post_rst_idle", {31'b0, msync_n}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
